mem_reinit_ctrl: RTL

Sequencer that owns the address/data/write-enable ports of one block-RAM `memory` instance. On command it re-initialises every word to a programmed pattern (FILL), or reads every word back and checks it against that pattern (VERIFY). When idle it passes a single user port through to the RAM. It sits between user logic and the RAM so that RAM contents can be restored and checked at run time without reloading the bitstream.

---
 rtl/mem_reinit_pkg.sv | 41 ++++
 rtl/mem_pat_gen.sv | 45 ++++
 rtl/mem_reinit_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_reinit_pkg.sv
// mem_reinit_pkg
// Shared types and constants for the RAM re-initialise / verify sequencer.
//   state_t    : sequencer states
//   mode_t     : command selected with start (fill or verify)
//   pat_kind_t : pattern source (constant value or word address)
//   ERR_SAT    : saturation value of the mismatch counter
//   sat_inc()  : saturating increment used by the mismatch counter
package mem_reinit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FILL   = 3'd1,
        ST_VERIFY = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    typedef enum logic {
        MODE_FILL   = 1'b0,
        MODE_VERIFY = 1'b1
    } mode_t;

    typedef enum logic {
        PAT_CONST = 1'b0,
        PAT_ADDR  = 1'b1
    } pat_kind_t;

    localparam logic [31:0] ERR_SAT = 32'hFFFF_FFFF;

    // Increment that sticks at ERR_SAT instead of wrapping to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        logic [31:0] r;
        if (v == ERR_SAT) begin
            r = v;
        end else begin
            r = v + 32'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_pat_gen.sv
// mem_pat_gen
// Combinational pattern generator: returns the word expected at a given
// RAM address for the selected pattern kind.
//   addr : word address (AW bits)
//   kind : PAT_CONST -> val, PAT_ADDR -> addr truncated / zero-extended
//   val  : constant pattern value
//   pat  : resulting pattern word (WID_MEM bits)
module mem_pat_gen
    import mem_reinit_pkg::*;
#(
    parameter int WID_MEM = 1,
    parameter int AW      = 1
) (
    input  logic [AW-1:0]      addr,
    input  pat_kind_t          kind,
    input  logic [WID_MEM-1:0] val,
    output logic [WID_MEM-1:0] pat
);

    logic [WID_MEM-1:0] addr_pat_s;
    // Address bits above WID_MEM do not take part in the address pattern.
    logic               unused_addr_s;

    assign unused_addr_s = ^addr;

    // Bit i of the address pattern is address bit i, or zero past the address width.
    for (genvar i = 0; i < WID_MEM; i++) begin : g_bit
        if (i < AW) begin : g_addr
            assign addr_pat_s[i] = addr[i];
        end else begin : g_zero
            assign addr_pat_s[i] = 1'b0;
        end
    end

    // Select the pattern source.
    always_comb begin
        pat = val;
        case (kind)
            PAT_ADDR:  pat = addr_pat_s;
            PAT_CONST: pat = val;
            default:   pat = val;
        endcase
    end

endmodule

// File: rtl/mem_reinit_ctrl.sv
// mem_reinit_ctrl
// Owns the port of one block RAM. When idle the user port passes straight
// through; on start it either writes a pattern into every word (fill) or
// reads every word back and counts mismatches against the pattern (verify).
//   clk, reset                : clock, asynchronous active-high reset
//   start, mode, pat_kind,
//   pat_val                   : command strobe and its arguments (idle only)
//   busy, done                : sequence running / one-cycle completion pulse
//   err_count, first_err_addr,
//   err_valid                 : results of the last verify
//   user_*                    : user RAM port, user_gnt = user owns the RAM
//   mem_*                     : RAM port (mem_dout has one-cycle read latency)
module mem_reinit_ctrl
    import mem_reinit_pkg::*;
#(
    parameter int WID_MEM   = 1,
    parameter int DEPTH_MEM = 16384,
    parameter int AW        = $clog2(DEPTH_MEM)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               mode,
    input  logic               pat_kind,
    input  logic [WID_MEM-1:0] pat_val,
    output logic               busy,
    output logic               done,
    output logic [31:0]        err_count,
    output logic [31:0]        first_err_addr,
    output logic               err_valid,
    input  logic [31:0]        user_raddr,
    input  logic [31:0]        user_waddr,
    input  logic [WID_MEM-1:0] user_din,
    input  logic               user_we,
    output logic [WID_MEM-1:0] user_dout,
    output logic               user_gnt,
    output logic [31:0]        mem_raddr,
    output logic [31:0]        mem_waddr,
    output logic [WID_MEM-1:0] mem_din,
    output logic               mem_we,
    input  logic [WID_MEM-1:0] mem_dout
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH_MEM - 1);

    state_t             state_q, state_d;
    mode_t              mode_q, mode_d;
    pat_kind_t          kind_q, kind_d;
    logic [WID_MEM-1:0] val_q, val_d;
    logic [AW-1:0]      addr_q, addr_d;
    logic [AW-1:0]      cmp_addr_q, cmp_addr_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic [31:0]        err_count_q, err_count_d;
    logic [31:0]        first_err_addr_q, first_err_addr_d;
    logic               err_valid_q, err_valid_d;
    logic [WID_MEM-1:0] dout_hold_q, dout_hold_d;

    logic [WID_MEM-1:0] wr_pat_s;
    logic [WID_MEM-1:0] cmp_pat_s;
    logic               busy_s;
    logic               mismatch_s;

    // Pattern for the word being written this cycle.
    mem_pat_gen #(.WID_MEM(WID_MEM), .AW(AW)) u_wr_pat (
        .addr (addr_q),
        .kind (kind_q),
        .val  (val_q),
        .pat  (wr_pat_s)
    );

    // Pattern for the word whose read data arrives this cycle.
    mem_pat_gen #(.WID_MEM(WID_MEM), .AW(AW)) u_cmp_pat (
        .addr (cmp_addr_q),
        .kind (kind_q),
        .val  (val_q),
        .pat  (cmp_pat_s)
    );

    // DONE is not busy so the user regains the RAM in the same cycle done pulses.
    assign busy_s     = (state_q == ST_FILL) || (state_q == ST_VERIFY) || (state_q == ST_DRAIN);
    assign mismatch_s = cmp_vld_q && (mem_dout != cmp_pat_s);

    assign busy           = busy_s;
    assign done           = (state_q == ST_DONE);
    assign user_gnt       = !busy_s;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign err_valid      = err_valid_q;

    // Next-state, address walk and error accumulation.
    always_comb begin
        state_d          = state_q;
        mode_d           = mode_q;
        kind_d           = kind_q;
        val_d            = val_q;
        addr_d           = addr_q;
        cmp_addr_d       = addr_q;
        cmp_vld_d        = 1'b0;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;
        err_valid_d      = err_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode_t'(mode);
                    kind_d = pat_kind_t'(pat_kind);
                    val_d  = pat_val;
                    addr_d = '0;
                    if (mode_t'(mode) == MODE_VERIFY) begin
                        err_count_d      = 32'd0;
                        first_err_addr_d = 32'd0;
                        err_valid_d      = 1'b0;
                        state_d          = ST_VERIFY;
                    end else begin
                        state_d = ST_FILL;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FILL: begin
                addr_d = addr_q + AW'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_FILL;
                end
            end
            ST_VERIFY: begin
                // Read data returns next cycle, so remember which address it belongs to.
                cmp_vld_d  = 1'b1;
                cmp_addr_d = addr_q;
                addr_d     = addr_q + AW'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_VERIFY;
                end
            end
            ST_DRAIN: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // cmp_vld_q is never set in IDLE, so this cannot collide with the clear above.
        if (mismatch_s) begin
            err_count_d = sat_inc(err_count_q);
            if (!err_valid_q) begin
                first_err_addr_d = 32'(cmp_addr_q);
                err_valid_d      = 1'b1;
            end else begin
                first_err_addr_d = first_err_addr_q;
                err_valid_d      = err_valid_q;
            end
        end else begin
            err_count_d = err_count_d;
        end
    end

    // Keep the last read data the user saw while the sequencer owns the RAM.
    always_comb begin
        dout_hold_d = mem_dout;
        if (busy_s) begin
            dout_hold_d = dout_hold_q;
        end else begin
            dout_hold_d = mem_dout;
        end
    end

    // RAM port ownership; reset blocks every write path immediately.
    always_comb begin
        mem_raddr = user_raddr;
        mem_waddr = user_waddr;
        mem_din   = user_din;
        mem_we    = user_we & ~reset;
        user_dout = mem_dout;
        if (busy_s) begin
            mem_raddr = 32'(addr_q);
            mem_waddr = 32'(addr_q);
            mem_din   = wr_pat_s;
            mem_we    = (state_q == ST_FILL) & ~reset;
            user_dout = dout_hold_q;
        end else begin
            mem_raddr = user_raddr;
            mem_waddr = user_waddr;
            mem_din   = user_din;
            mem_we    = user_we & ~reset;
            user_dout = mem_dout;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= ST_IDLE;
            mode_q           <= MODE_FILL;
            kind_q           <= PAT_CONST;
            val_q            <= '0;
            addr_q           <= '0;
            cmp_addr_q       <= '0;
            cmp_vld_q        <= 1'b0;
            err_count_q      <= 32'd0;
            first_err_addr_q <= 32'd0;
            err_valid_q      <= 1'b0;
            dout_hold_q      <= '0;
        end else begin
            state_q          <= state_d;
            mode_q           <= mode_d;
            kind_q           <= kind_d;
            val_q            <= val_d;
            addr_q           <= addr_d;
            cmp_addr_q       <= cmp_addr_d;
            cmp_vld_q        <= cmp_vld_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            err_valid_q      <= err_valid_d;
            dout_hold_q      <= dout_hold_d;
        end
    end

endmodule
